// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter sharing one fixed-latency pipelined adder, with tagged in-order responses
module add_arbiter #(
  parameter int num_req = 4,
  parameter int latency = 3,
  parameter int a_bits = 32,
  parameter int b_bits = 32,
  parameter int q_bits = 32,
  localparam int id_bits = (num_req > 1) ? $clog2(num_req) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [num_req-1:0]          i_req_valid,
  input  logic [num_req*a_bits-1:0]   i_req_a,
  input  logic [num_req*b_bits-1:0]   i_req_b,
  output logic [num_req-1:0]          o_req_ready,
  output logic [a_bits-1:0]           o_add_a,
  output logic [b_bits-1:0]           o_add_b,
  input  logic [q_bits-1:0]           i_add_q,
  output logic                        o_rsp_valid,
  output logic [id_bits-1:0]          o_rsp_id,
  output logic [q_bits-1:0]           o_rsp_q,
  output logic                        o_busy
);
  logic [id_bits-1:0] ptr;
  logic [id_bits-1:0] gnt_id;
  logic [id_bits-1:0] idx;
  logic gnt_any;
  logic [latency-1:0] tag_v;
  logic [latency-1:0][id_bits-1:0] tag_id;
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int i = num_req - 1; i >= 0; i--) begin
      idx = id_bits'((int'(ptr) + i) % num_req);
      if (i_req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign o_req_ready = gnt_any ? num_req'(1) << gnt_id : '0;
  assign o_add_a = gnt_any ? i_req_a[int'(gnt_id)*a_bits +: a_bits] : '0;
  assign o_add_b = gnt_any ? i_req_b[int'(gnt_id)*b_bits +: b_bits] : '0;
  assign o_busy = |tag_v | o_rsp_valid;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
      tag_v <= '0;
      tag_id <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id <= '0;
      o_rsp_q <= '0;
    end else begin
      if (gnt_any) ptr <= (gnt_id == id_bits'(num_req - 1)) ? '0 : gnt_id + 1'b1;
      tag_v[0] <= gnt_any;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < latency; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      o_rsp_valid <= tag_v[latency-1];
      o_rsp_id <= tag_id[latency-1];
      if (tag_v[latency-1]) o_rsp_q <= i_add_q;
    end
  end
endmodule
